// File: rtl/popcnt_stat_if.sv
// Sample stream in, burst statistics out, plus sticky error flags.
// The slave modport is the statistics block; the master modport drives it.
interface popcnt_stat_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_cnt;
  logic [15:0] out_sum;
  logic [7:0]  out_max;
  logic [7:0]  out_min;
  logic        range_err;
  logic        drop_err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_cnt, out_sum, out_max, out_min,
           range_err, drop_err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_cnt, out_sum, out_max, out_min,
           range_err, drop_err
  );
endinterface

// File: rtl/popcnt_stat.sv
// Burst statistics (count/sum/max/min) over a popcount sample stream.
// state | meaning
// IDLE  | waiting for the first sample of a burst
// ACC   | accumulating; leaves on a gap or when the 255th sample lands
// HOLD  | statistics presented until out_ready; samples here are dropped
module popcnt_stat (
  input  logic         clk,
  input  logic         rst_n,
  popcnt_stat_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] sum_q;
  logic [7:0]  max_q;
  logic [7:0]  min_q;
  logic        range_err_q;
  logic        drop_err_q;

  logic        over_d;
  logic [7:0]  samp_d;

  always_comb begin
    over_d = (bus.in_data > 8'd128);
    samp_d = over_d ? 8'd128 : bus.in_data;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sum_q       <= 16'd0;
      max_q       <= 8'd0;
      min_q       <= 8'd0;
      range_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= ACC;
            cnt_q   <= 8'd1;
            sum_q   <= {8'd0, samp_d};
            max_q   <= samp_d;
            min_q   <= samp_d;
            if (over_d) range_err_q <= 1'b1;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            cnt_q <= cnt_q + 8'd1;
            sum_q <= sum_q + {8'd0, samp_d};
            if (samp_d > max_q) max_q <= samp_d;
            if (samp_d < min_q) min_q <= samp_d;
            if (over_d) range_err_q <= 1'b1;
            // This sample is the 255th: counter is full, present now.
            if (cnt_q == 8'd254) state_q <= HOLD;
          end else begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.in_valid) drop_err_q <= 1'b1;
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_cnt   = cnt_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_max   = max_q;
  assign bus.out_min   = min_q;
  assign bus.range_err = range_err_q;
  assign bus.drop_err  = drop_err_q;
endmodule
